// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared encodings and state type for the instruction fetch unit
package ifu_pkg;

  // PCSrc encodings, shared with control_unit
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - fetched {PC, Instr} buffer with synchronous flush and occupancy count
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  // a push into a full buffer is only legal when the head leaves in the same cycle
  assign do_push = push_i && (!full || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // pointer and occupancy bookkeeping; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage array, contents only meaningful below count
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, pipelined imem requests, decode buffer, PCSrc redirects (option: IFU_MISALIGN_TRAP_EN)
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        IMemReqValid,
  input  logic        IMemReqReady,
  output logic [31:0] IMemReqAddr,
  input  logic        IMemRespValid,
  input  logic [31:0] IMemRespData,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic        FetchFault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;   // PC of the next response that will be kept
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic [2:0]  stale_cnt_q, stale_cnt_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [63:0]   fifo_head;
  logic [7:0]    credit_sum;
  logic          req_fire, resp_discard, redirect, unused_bits;
  logic [31:0]   raw_target, target;

  assign credit_sum   = 8'(out_cnt_q) + 8'(fifo_count);
  // every outstanding request holds a FIFO slot, so a response never finds it full
  assign IMemReqValid = (state_q == RUN) && (out_cnt_q < 3'(MAX_OUTSTANDING))
                        && (credit_sum < 8'(FIFO_DEPTH));
  assign IMemReqAddr  = fetch_pc_q;
  assign req_fire     = IMemReqValid && IMemReqReady;
  assign resp_discard = IMemRespValid && (stale_cnt_q != 3'd0);
  assign redirect     = (state_q == RUN) && ((PCSrc == PCSRC_BRANCH) || (PCSrc == PCSRC_JALR));
  assign raw_target   = (PCSrc == PCSRC_JALR) ? {ALUResult[31:1], 1'b0} : PCTarget;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_q, fault_d, bad_target;
  assign target      = raw_target;
  assign bad_target  = (raw_target[1:0] != 2'b00);
  assign unused_bits = ALUResult[0];
  assign FetchFault  = fault_q;
`else
  assign target      = {raw_target[31:2], 2'b00};
  assign unused_bits = ^{ALUResult[0], raw_target[1:0]};
`endif

  assign InstrValid = !fifo_empty;
  assign fifo_pop   = InstrValid && InstrReady;
  assign Instr      = fifo_empty ? NOP_INSTR : fifo_head[31:0];
  assign PC         = fifo_empty ? resp_pc_q : fifo_head[63:32];
  assign PCPlus4    = PC + 32'd4;

  // next-state: FSM, fetch PC, outstanding/stale accounting, FIFO controls
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    stale_cnt_d = stale_cnt_q;
    out_cnt_d   = out_cnt_q + 3'(req_fire) - 3'(IMemRespValid);
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    fault_d     = fault_q;
`endif
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        if (resp_discard) begin
          stale_cnt_d = stale_cnt_q - 3'd1;
        end else if (IMemRespValid) begin
          fifo_push = 1'b1;
          resp_pc_d = resp_pc_q + 32'd4;
        end
        if (redirect) begin
          // everything still in flight after this edge belongs to the old path
          fetch_pc_d  = target;
          resp_pc_d   = target;
          stale_cnt_d = out_cnt_d;
          fifo_push   = 1'b0;
          fifo_flush  = 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
          if (bad_target) begin
            state_d = HALT;
            fault_d = 1'b1;
          end
`endif
        end
      end
      HALT: begin
        if (resp_discard) stale_cnt_d = stale_cnt_q - 3'd1;
      end
      default: state_d = BOOT;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      out_cnt_q   <= 3'd0;
      stale_cnt_q <= 3'd0;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      out_cnt_q   <= out_cnt_d;
      stale_cnt_q <= stale_cnt_d;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_q     <= fault_d;
`endif
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i ({resp_pc_q, IMemRespData}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IMemReqValid;
  logic        IMemReqReady;
  logic [31:0] IMemReqAddr;
  logic        IMemRespValid = 1'b0;
  logic [31:0] IMemRespData  = 32'h0;
  logic [31:0] Instr, PC, PCPlus4;
  logic        InstrValid;
  logic        InstrReady;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget, ALUResult;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        FetchFault;
`endif

  int          checks = 0;
  int          errors = 0;
  logic        resp_en;
  logic [31:0] exp_pc;
  logic [31:0] mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] unused_pop;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IMemReqValid  (IMemReqValid),
    .IMemReqReady  (IMemReqReady),
    .IMemReqAddr   (IMemReqAddr),
    .IMemRespValid (IMemRespValid),
    .IMemRespData  (IMemRespData),
    .Instr         (Instr),
    .PC            (PC),
    .PCPlus4       (PCPlus4),
    .InstrValid    (InstrValid),
    .InstrReady    (InstrReady),
    .PCSrc         (PCSrc),
    .PCTarget      (PCTarget),
    .ALUResult     (ALUResult)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .FetchFault    (FetchFault)
`endif
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // in-order memory: answers each accepted request one cycle later while resp_en is set
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (IMemRespValid && mq.size() > 0) unused_pop = mq.pop_front();
      if (IMemReqValid && IMemReqReady) begin
        mq.push_back(IMemReqAddr);
        acc_log.push_back(IMemReqAddr);
      end
    end
    #1;
    if (resp_en && mq.size() > 0) begin
      IMemRespValid = 1'b1;
      IMemRespData  = data_of(mq[0]);
    end else begin
      IMemRespValid = 1'b0;
      IMemRespData  = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reqvalid"}, {31'b0, IMemReqValid}, 32'd0);
    chk({tag, "_reqaddr"}, IMemReqAddr, 32'h0);
    chk({tag, "_instrvalid"}, {31'b0, InstrValid}, 32'd0);
    chk({tag, "_instr"}, Instr, 32'h0000_0013);
    chk({tag, "_pc"}, PC, 32'h0);
    chk({tag, "_pcplus4"}, PCPlus4, 32'h4);
  endtask

  // consume n entries in order, each must carry exp_pc and its memory word
  task automatic drain(input int n, input int budget, input string tag);
    int got = 0;
    InstrReady = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      if (InstrValid) begin
        chk({tag, "_pc"}, PC, exp_pc);
        chk({tag, "_instr"}, Instr, data_of(exp_pc));
        chk({tag, "_pcplus4"}, PCPlus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      step();
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic redirect(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    PCSrc     = src;
    PCTarget  = tgt;
    ALUResult = alu;
    step();
    PCSrc = 2'b00;
  endtask

  initial begin
    int mark;
    int found;
    rst_n        = 1'b0;
    IMemReqReady = 1'b1;
    resp_en      = 1'b1;
    InstrReady   = 1'b0;
    PCSrc        = 2'b00;
    PCTarget     = 32'h0;
    ALUResult    = 32'h0;
    exp_pc       = 32'h0;
    #1;
    chk_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;

    // boot: one cycle in BOOT, request at RESET_PC, first valid on the third edge
    step();
    chk("boot_e1_instrvalid", {31'b0, InstrValid}, 32'd0);
    chk("boot_e1_reqvalid", {31'b0, IMemReqValid}, 32'd1);
    chk("boot_e1_reqaddr", IMemReqAddr, 32'h0);
    InstrReady = 1'b1;
    step();
    chk("boot_e2_instrvalid", {31'b0, InstrValid}, 32'd0);
    step();
    chk("boot_e3_instrvalid", {31'b0, InstrValid}, 32'd1);
    exp_pc = 32'h0;
    drain(8, 40, "seq");
    for (int i = 0; i < 8; i++) chk("seq_reqaddr", acc_log[i], 32'(i * 4));

    // decode stall: request credit runs out, nothing is lost
    InstrReady = 1'b0;
    mark = acc_log.size();
    for (int i = 0; i < 10; i++) step();
    chk("stall_reqvalid", {31'b0, IMemReqValid}, 32'd0);
    chk("stall_instrvalid", {31'b0, InstrValid}, 32'd1);
    chk("stall_head_pc", PC, exp_pc);
    chk("stall_accepts_le2", {31'b0, (acc_log.size() - mark) <= 2}, 32'd1);
    drain(6, 40, "stall_resume");

    // branch with two requests in flight: both answers must be dropped
    resp_en = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("br_inflight", 32'(mq.size()), 32'd2);
    chk("br_pre_instrvalid", {31'b0, InstrValid}, 32'd0);
    redirect(2'b01, 32'h0000_0100, 32'h0);
    chk("br_reqaddr", IMemReqAddr, 32'h0000_0100);
    chk("br_instrvalid", {31'b0, InstrValid}, 32'd0);
    resp_en = 1'b1;
    exp_pc  = 32'h0000_0100;
    drain(4, 40, "br");

    // redirect to the top word: PC and PCPlus4 wrap
    redirect(2'b01, 32'hFFFF_FFFC, 32'h0);
    exp_pc = 32'hFFFF_FFFC;
    drain(3, 40, "wrap");

    // redirect on an edge that both accepts a request and pushes a response
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (IMemReqValid && IMemRespValid && !InstrValid) found = 1;
      else step();
    end
    chk("acc_push_found", 32'(found), 32'd1);
    redirect(2'b01, 32'h0000_0400, 32'h0);
    chk("acc_push_instrvalid", {31'b0, InstrValid}, 32'd0);
    chk("acc_push_reqaddr", IMemReqAddr, 32'h0000_0400);
    exp_pc = 32'h0000_0400;
    drain(3, 40, "acc_push");

    // redirect on an edge that both pops the head and pushes a response
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (InstrValid && IMemRespValid) found = 1;
      else step();
    end
    chk("pop_push_found", 32'(found), 32'd1);
    redirect(2'b01, 32'h0000_0500, 32'h0);
    chk("pop_push_instrvalid", {31'b0, InstrValid}, 32'd0);
    exp_pc = 32'h0000_0500;
    drain(3, 40, "pop_push");

    // JALR to an odd, half-aligned address
    redirect(2'b10, 32'h0, 32'h0000_0203);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("jalr_fault", {31'b0, FetchFault}, 32'd1);
    chk("jalr_reqvalid", {31'b0, IMemReqValid}, 32'd0);
    chk("jalr_instrvalid", {31'b0, InstrValid}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("jalr_fault_sticky", {31'b0, FetchFault}, 32'd1);
    chk("jalr_reqvalid_held", {31'b0, IMemReqValid}, 32'd0);
`else
    chk("jalr_reqaddr", IMemReqAddr, 32'h0000_0200);
    exp_pc = 32'h0000_0200;
    drain(3, 40, "jalr");
`endif

    // asynchronous reset in the middle of traffic, then a clean restart
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
`ifdef IFU_MISALIGN_TRAP_EN
    chk("midreset_fault", {31'b0, FetchFault}, 32'd0);
`endif
    step();
    step();
    mark  = acc_log.size();
    rst_n = 1'b1;
    step();
    chk("restart_reqvalid", {31'b0, IMemReqValid}, 32'd1);
    chk("restart_reqaddr", IMemReqAddr, 32'h0);
    step();
    chk("restart_first_accept", acc_log[mark], 32'h0);
    exp_pc = 32'h0;
    drain(4, 40, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
